// File: rtl/dsp_pkg.sv
// Shared DSP helpers: constant log2, derived sum width and a power-of-two test
// used by the filter blocks when they are elaborated.
package dsp_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Summing 2**k samples grows the signed range by exactly k bits.
   function automatic int sum_width(input int w, input int taps);
      return w + clog2(taps);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/signed_delay_line.sv
// Enabled shift register of TAPS samples; dout_oldest is the sample about to
// fall out of the window on the next shift.
module signed_delay_line #(
   parameter int WIDTH = 8,
   parameter int TAPS  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout_oldest
);

   logic [TAPS-1:0][WIDTH-1:0] tap;

   always_ff @(posedge clk) begin
      if (rst || clr)
         tap <= '0;
      else if (shift_en)
         tap <= {tap[TAPS-2:0], din};
   end

   assign dout_oldest = tap[TAPS-1];

endmodule

// File: rtl/moving_sum_filter.sv
// Boxcar filter: running accumulator over the last TAPS accepted samples,
// with fill tracking, synchronous clear and a floor-rounded average.
module moving_sum_filter
   import dsp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAPS  = 8,
   parameter int SUM_W = sum_width(WIDTH, TAPS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    clear,
   output logic                    out_valid,
   output logic signed [SUM_W-1:0] out_sum,
   output logic signed [WIDTH-1:0] out_avg,
   output logic [clog2(TAPS):0]    fill_count,
   output logic                    full
);

   localparam int LOG2 = clog2(TAPS);
   localparam int CW   = LOG2 + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(TAPS);

   if (!is_pow2(TAPS) || TAPS < 2 || TAPS > 256) begin : g_taps_chk
      $error("moving_sum_filter: TAPS must be a power of two in 2..256");
   end

   logic                    accept;
   logic [WIDTH-1:0]        oldest;
   logic signed [SUM_W-1:0] acc;
   logic [CW-1:0]           fill_next;

   // A sample presented together with clear is dropped.
   assign accept = in_valid && !clear;

   signed_delay_line #(.WIDTH(WIDTH), .TAPS(TAPS)) u_dly (
      .clk         (clk),
      .rst         (rst),
      .clr         (clear),
      .shift_en    (accept),
      .din         (in_data),
      .dout_oldest (oldest)
   );

   assign fill_next = (fill_count == FULL_CNT) ? fill_count : fill_count + 1'b1;

   // Empty taps read as zero, so the same update is exact during fill.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc        <= '0;
         fill_count <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= accept && (fill_next == FULL_CNT);
         if (accept) begin
            acc <= acc
                 + {{(SUM_W-WIDTH){in_data[WIDTH-1]}}, in_data}
                 - {{(SUM_W-WIDTH){oldest[WIDTH-1]}}, oldest};
            fill_count <= fill_next;
         end
      end
   end

   assign out_sum = acc;
   assign out_avg = WIDTH'(acc >>> LOG2);
   assign full    = (fill_count == FULL_CNT);

endmodule

// File: tb/tb_moving_sum_filter.sv
// Directed bench for moving_sum_filter (WIDTH=8, TAPS=8) with hand-computed sums.
module tb_moving_sum_filter;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic signed [7:0] in_data = '0;
   logic              clear = 1'b0;
   logic              out_valid;
   logic signed [10:0] out_sum;
   logic signed [7:0] out_avg;
   logic [3:0]        fill_count;
   logic              full;

   int passed = 0;
   int total  = 0;

   moving_sum_filter #(.WIDTH(8), .TAPS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_sum    (out_sum),
      .out_avg    (out_avg),
      .fill_count (fill_count),
      .full       (full)
   );

   always #5 clk = ~clk;

   task automatic step(input logic v, input int d, input logic c, input logic r);
      in_valid = v;
      in_data  = 8'(d);
      clear    = c;
      rst      = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input int v, input int s, input int a,
                          input int f, input int fl);
      chk({tag, ".valid"}, int'(out_valid), v);
      chk({tag, ".sum"}, int'(out_sum), s);
      chk({tag, ".avg"}, int'(out_avg), a);
      chk({tag, ".fill"}, int'(fill_count), f);
      chk({tag, ".full"}, int'(full), fl);
   endtask

   initial begin
      int slide_exp[8];
      slide_exp = '{197, 314, 431, 548, 665, 782, 899, 1016};

      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk_all("reset", 0, 0, 0, 0, 0);

      // partial activity, then reset mid-stream
      for (int i = 0; i < 4; i++) step(1, 10, 0, 0);
      chk("pre_rst.sum", int'(out_sum), 40);
      step(1, 10, 0, 1);
      step(0, 0, 0, 1);
      chk_all("mid_rst", 0, 0, 0, 0, 0);

      // fill: 7 accepts without a pulse, pulse on the 8th
      for (int i = 1; i <= 7; i++) begin
         step(1, 10, 0, 0);
         chk($sformatf("fill%0d.valid", i), int'(out_valid), 0);
         chk($sformatf("fill%0d.cnt", i), int'(fill_count), i);
      end
      step(1, 10, 0, 0);
      chk_all("fill8", 1, 80, 10, 8, 1);

      // slide in 127s
      for (int i = 0; i < 8; i++) begin
         step(1, 127, 0, 0);
         chk($sformatf("slide%0d.valid", i), int'(out_valid), 1);
         chk($sformatf("slide%0d.sum", i), int'(out_sum), slide_exp[i]);
      end
      chk("slide.avg", int'(out_avg), 127);
      step(0, 0, 0, 0);
      chk("idle.valid", int'(out_valid), 0);
      chk("idle.sum", int'(out_sum), 1016);

      // clear, then most negative samples
      step(0, 0, 1, 0);
      chk_all("clear1", 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(1, -128, 0, 0);
      chk("neg7.valid", int'(out_valid), 0);
      chk("neg7.sum", int'(out_sum), -896);
      step(1, -128, 0, 0);
      chk_all("neg8", 1, -1024, -128, 8, 1);

      // floor rounding of -1/8
      step(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
      step(1, -1, 0, 0);
      chk_all("floor", 1, -1, -1, 8, 1);

      // gapped stream of 5s
      step(0, 0, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         step(1, 5, 0, 0);
         chk($sformatf("gap_acc%0d.valid", i), int'(out_valid), (i == 8) ? 1 : 0);
         step(0, 5, 0, 0);
         chk($sformatf("gap_idle%0d.valid", i), int'(out_valid), 0);
      end
      chk_all("gap_end", 0, 40, 5, 8, 1);

      // clear colliding with a valid sample while full
      step(1, 50, 1, 0);
      chk_all("collide", 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
      chk("post_collide.sum", int'(out_sum), 7);
      chk("post_collide.fill", int'(fill_count), 7);
      chk("post_collide.valid", int'(out_valid), 0);
      step(1, 1, 0, 0);
      chk("post_collide8.sum", int'(out_sum), 8);
      chk("post_collide8.valid", int'(out_valid), 1);

      step(0, 0, 0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
